// File: rtl/analog_sample_bank.sv
// analog_sample_bank
// Multi-channel ADC capture bank. A two-state sequencer walks the ADC mux
// round-robin over NUM_CH channels. Every returned sample for a valid channel
// index lands in that channel's holding register. The bank raises per-channel
// valid flags, a frame_done pulse on each completed sweep, and a timeout_err
// pulse when a conversion never arrives.
//
// Optional build macro: AVG_FILTER_EN
//   defined   -> each holding register keeps an exponential average
//                new = old + ((sample - old) >>> 2). A channel whose valid
//                flag is clear loads the raw sample instead.
//   undefined -> samples are stored raw and no filter logic is built.

module analog_sample_bank #(
    parameter int NUM_CH   = 10,
    parameter int SAMPLE_W = 10,
    parameter int CH_W     = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    output logic [CH_W-1:0]              channel,
    input  logic                         new_sample,
    input  logic [SAMPLE_W-1:0]          sample,
    input  logic [CH_W-1:0]              sample_channel,
    output logic [NUM_CH*SAMPLE_W-1:0]   ch_data,
    output logic [NUM_CH-1:0]            ch_valid,
    output logic                         frame_done,
    output logic                         timeout_err,
    output logic [7:0]                   led
);

    // The counter is wide enough for the largest supported TIMEOUT (65535).
    localparam int                CNT_W        = 16;
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CH_W-1:0]   LAST_CH      = CH_W'(NUM_CH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              match;
    logic              timeout_hit;
    logic              last_ch;
    logic [CH_W-1:0]   next_channel;

`ifdef AVG_FILTER_EN
    // The difference is formed one bit wider and signed. The shifted step
    // always lies between 0 and (sample - old), so the truncated sum stays in
    // range.
    function automatic logic [SAMPLE_W-1:0] avg_step(
        input logic [SAMPLE_W-1:0] old_val,
        input logic [SAMPLE_W-1:0] new_val
    );
        logic signed [SAMPLE_W:0] diff;
        logic signed [SAMPLE_W:0] step;
        diff = $signed({1'b0, new_val}) - $signed({1'b0, old_val});
        step = diff >>> 2;
        return SAMPLE_W'({1'b0, old_val} + step);
    endfunction
`endif

    // Decide whether this cycle completes the requested conversion or gives up on it.
    always_comb begin
        match        = new_sample && (sample_channel == channel);
        timeout_hit  = (state == ST_WAIT) && enable && !match && (wait_cnt == TIMEOUT_LAST);
        last_ch      = (channel == LAST_CH);
        next_channel = last_ch ? '0 : channel + CH_W'(1);
    end

    // Sequencer: park in IDLE, or step through channels on each match or timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            channel     <= '0;
            wait_cnt    <= '0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (enable) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!enable) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else if (match || timeout_hit) begin
                        channel     <= next_channel;
                        frame_done  <= last_ch;
                        timeout_err <= timeout_hit;
                        wait_cnt    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Capture path: store any in-range sample whatever the sequencer state, and drop valid on a timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_data  <= '0;
            ch_valid <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (timeout_hit && (channel == CH_W'(k))) begin
                    ch_valid[k] <= 1'b0;
                end
                if (new_sample && (sample_channel == CH_W'(k))) begin
                    ch_valid[k] <= 1'b1;
`ifdef AVG_FILTER_EN
                    if (ch_valid[k]) begin
                        ch_data[k*SAMPLE_W +: SAMPLE_W] <=
                            avg_step(ch_data[k*SAMPLE_W +: SAMPLE_W], sample);
                    end else begin
                        ch_data[k*SAMPLE_W +: SAMPLE_W] <= sample;
                    end
`else
                    ch_data[k*SAMPLE_W +: SAMPLE_W] <= sample;
`endif
                end
            end
        end
    end

    // The debug LEDs show the top byte of channel 0 and follow its register directly.
    assign led = ch_data[SAMPLE_W-1 -: 8];

endmodule

// File: tb/tb_analog_sample_bank.sv
// tb_analog_sample_bank
// Directed bench for analog_sample_bank. The initial block plays the ADC.
// Each injected sample updates a shadow model and pushes the expected
// register image to a scoreboard queue. The bench pops that image and
// compares it one clock later. Honours AVG_FILTER_EN when it is defined.

module tb_analog_sample_bank;

    localparam int NUM_CH   = 10;
    localparam int SAMPLE_W = 10;
    localparam int CH_W     = 4;
    localparam int TIMEOUT  = 20;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic                        enable = 1'b0;
    logic [CH_W-1:0]             channel;
    logic                        new_sample = 1'b0;
    logic [SAMPLE_W-1:0]         sample = '0;
    logic [CH_W-1:0]             sample_channel = '0;
    logic [NUM_CH*SAMPLE_W-1:0]  ch_data;
    logic [NUM_CH-1:0]           ch_valid;
    logic                        frame_done;
    logic                        timeout_err;
    logic [7:0]                  led;

    typedef struct {
        logic [NUM_CH*SAMPLE_W-1:0] data;
        logic [NUM_CH-1:0]          valid;
        logic [CH_W-1:0]            chan;
        logic                       frame;
        logic                       tmo;
        logic [7:0]                 led;
    } exp_t;

    exp_t                 sb[$];
    logic [SAMPLE_W-1:0]  model_data [NUM_CH];
    logic [NUM_CH-1:0]    model_valid;
    logic [CH_W-1:0]      exp_ch;
    logic                 bench_wait;
    logic                 stray;
    int                   checks = 0;
    int                   errors = 0;

    analog_sample_bank #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W),
        .CH_W     (CH_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .channel        (channel),
        .new_sample     (new_sample),
        .sample         (sample),
        .sample_channel (sample_channel),
        .ch_data        (ch_data),
        .ch_valid       (ch_valid),
        .frame_done     (frame_done),
        .timeout_err    (timeout_err),
        .led            (led)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
        return (c == CH_W'(NUM_CH - 1)) ? '0 : c + CH_W'(1);
    endfunction

    function automatic logic [NUM_CH*SAMPLE_W-1:0] pack_model();
        logic [NUM_CH*SAMPLE_W-1:0] p;
        p = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            p[k*SAMPLE_W +: SAMPLE_W] = model_data[k];
        end
        return p;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            model_data[k] = '0;
        end
        model_valid = '0;
        exp_ch      = '0;
        bench_wait  = 1'b0;
    endtask

    function automatic logic [255:0] all_outputs();
        return 256'({channel, ch_valid, ch_data, frame_done, timeout_err, led});
    endfunction

    // Drive a one-cycle sample strobe from a negedge, then compare one cycle later.
    task automatic applyStimulus(input logic [CH_W-1:0] ch, input logic [SAMPLE_W-1:0] val);
        exp_t e;
        exp_t got;
        logic adv;
        int   idx;
        idx            = int'(ch);
        new_sample     = 1'b1;
        sample_channel = ch;
        sample         = val;
        if (idx < NUM_CH) begin
`ifdef AVG_FILTER_EN
            if (model_valid[idx]) begin
                int o;
                int d;
                o = int'(model_data[idx]);
                d = int'(val) - o;
                d = d >>> 2;
                model_data[idx] = SAMPLE_W'(o + d);
            end else begin
                model_data[idx] = val;
            end
`else
            model_data[idx] = val;
`endif
            model_valid[idx] = 1'b1;
        end
        adv     = bench_wait && enable && (ch == exp_ch);
        e.frame = adv && (exp_ch == CH_W'(NUM_CH - 1));
        e.tmo   = 1'b0;
        if (adv) begin
            exp_ch = next_ch(exp_ch);
        end
        e.data  = pack_model();
        e.valid = model_valid;
        e.chan  = exp_ch;
        e.led   = model_data[0][SAMPLE_W-1 -: 8];
        sb.push_back(e);
        bench_wait = enable;
        @(negedge clk);
        new_sample     = 1'b0;
        sample_channel = '0;
        sample         = '0;
        got = sb.pop_front();
        checkOutput($sformatf("data after ch%0d", idx),        256'(ch_data),     256'(got.data));
        checkOutput($sformatf("valid after ch%0d", idx),       256'(ch_valid),    256'(got.valid));
        checkOutput($sformatf("channel after ch%0d", idx),     256'(channel),     256'(got.chan));
        checkOutput($sformatf("frame_done after ch%0d", idx),  256'(frame_done),  256'(got.frame));
        checkOutput($sformatf("timeout_err after ch%0d", idx), 256'(timeout_err), 256'(got.tmo));
        checkOutput($sformatf("led after ch%0d", idx),         256'(led),         256'(got.led));
    endtask

    // ADC responder: answer the requested channel after a fixed delay with 0x100 + channel.
    task automatic serveChannels(input int count, input int delay);
        for (int i = 0; i < count; i++) begin
            for (int d = 0; d < delay; d++) begin
                @(negedge clk);
                stray = stray | frame_done | timeout_err;
            end
            applyStimulus(channel, SAMPLE_W'(int'(channel) + 32'h100));
        end
    endtask

    // Directed sequence: reset, sweep, out-of-band, timeout, race, pause, reset, led.
    initial begin
        int  n;
        logic seen;
        model_reset();
        stray = 1'b0;

        #3 rst = 1'b1;
        #1 checkOutput("async reset", all_outputs(), 256'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checkOutput("idle hold", all_outputs(), 256'(0));
        end

        $display("[TB] full sweep");
        enable = 1'b1;
        @(negedge clk);
        bench_wait = 1'b1;
        serveChannels(10, 5);
        checkOutput("sweep valid", 256'(ch_valid), 256'(10'h3FF));
        checkOutput("sweep wrap", 256'(channel), 256'(0));
        for (int k = 0; k < NUM_CH; k++) begin
            checkOutput($sformatf("sweep ch%0d", k), 256'(ch_data[k*SAMPLE_W +: SAMPLE_W]), 256'(32'h100 + k));
        end

        $display("[TB] out-of-band samples");
        serveChannels(2, 2);
        @(negedge clk);
        applyStimulus(4'd7, 10'h2AA);
        checkOutput("oob channel held", 256'(channel), 256'(2));
        applyStimulus(4'd12, 10'h155);
        serveChannels(1, 1);

        $display("[TB] timeout on channel 3");
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (timeout_err === 1'b1) seen = 1'b1;
        end
        checkOutput("timeout latency", 256'(n), 256'(20));
        model_valid[3] = 1'b0;
        exp_ch         = 4'd4;
        checkOutput("timeout valid", 256'(ch_valid), 256'(model_valid));
        checkOutput("timeout channel", 256'(channel), 256'(4));
        checkOutput("timeout data kept", 256'(ch_data), 256'(pack_model()));
        @(negedge clk);
        checkOutput("timeout pulse width", 256'(timeout_err), 256'(0));

        $display("[TB] match on last timeout cycle");
        stray = 1'b0;
        repeat (18) begin
            @(negedge clk);
            stray = stray | frame_done | timeout_err;
        end
        applyStimulus(4'd4, 10'h0C4);
        checkOutput("no early timeout", 256'(stray), 256'(0));

        $display("[TB] enable drop and resume");
        enable = 1'b0;
        applyStimulus(4'd5, 10'h3C3);
        stray = 1'b0;
        repeat (30) begin
            @(negedge clk);
            stray = stray | frame_done | timeout_err;
        end
        checkOutput("paused channel", 256'(channel), 256'(5));
        checkOutput("paused no pulses", 256'(stray), 256'(0));
        enable = 1'b1;
        @(negedge clk);
        bench_wait = 1'b1;
        stray = 1'b0;
        serveChannels(5, 3);
        checkOutput("resume wrap", 256'(channel), 256'(0));
        checkOutput("resume no stray", 256'(stray), 256'(0));

        $display("[TB] reset mid-sweep");
        serveChannels(3, 2);
        enable = 1'b0;
        #2 rst = 1'b1;
        #1 checkOutput("mid-sweep reset", all_outputs(), 256'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] channel 0 history and led");
        applyStimulus(4'd0, 10'h000);
        applyStimulus(4'd0, 10'h100);
        applyStimulus(4'd0, 10'h3FF);
        checkOutput("idle capture channel", 256'(channel), 256'(0));
        enable = 1'b1;
        @(negedge clk);
        bench_wait = 1'b1;
        stray = 1'b0;
        serveChannels(1, 2);
        checkOutput("restart channel", 256'(channel), 256'(1));
        checkOutput("restart no stray", 256'(stray), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
